// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM state codes,
// the zero-register index and the four-bit pipeline control vectors.
package hazard_stall_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_LU_STALL = 2'd1,
        ST_BR_FLUSH = 2'd2
    } state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // Control vector bit order: {pc_write, if_id_write, if_id_flush, id_ex_bubble}
    localparam logic [3:0] CTL_FLUSH = 4'b1111;
    localparam logic [3:0] CTL_STALL = 4'b0001;
    localparam logic [3:0] CTL_PASS  = 4'b1100;
    localparam logic [3:0] CTL_RESET = 4'b0011;

endpackage : hazard_stall_ctrl_pkg

// File: rtl/hazard_stall_ctrl_if.sv
// Bundle between the pipeline datapath (master) and the hazard controller
// (slave): hazard inputs, pipeline control outputs and statistics.
interface hazard_stall_ctrl_if #(
    parameter int CNT_W = 16
) ();

    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_uses_rt;
    logic             ex_mem_read;
    logic [4:0]       ex_rt;
    logic             br_taken;
    logic             pc_write;
    logic             if_id_write;
    logic             if_id_flush;
    logic             id_ex_bubble;
    logic [1:0]       state;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt, br_taken,
        input  pc_write, if_id_write, if_id_flush, id_ex_bubble,
        input  state, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt, br_taken,
        output pc_write, if_id_write, if_id_flush, id_ex_bubble,
        output state, stall_cnt, flush_cnt
    );

endinterface : hazard_stall_ctrl_if

// File: rtl/hazard_stall_ctrl_load_use_detect.sv
// Combinational load-use compare: the load in EXE writes a register that the
// instruction in ID reads. Register 0 never creates a hazard.
module hazard_stall_ctrl_load_use_detect
    import hazard_stall_ctrl_pkg::*;
(
    input  logic [4:0] i_id_rs,
    input  logic [4:0] i_id_rt,
    input  logic       i_id_uses_rt,
    input  logic       i_ex_mem_read,
    input  logic [4:0] i_ex_rt,
    output logic       o_lu
);

    logic w_rs_hit;
    logic w_rt_hit;

    assign w_rs_hit = (i_ex_rt == i_id_rs);
    assign w_rt_hit = i_id_uses_rt & (i_ex_rt == i_id_rt);
    assign o_lu     = i_ex_mem_read & (i_ex_rt != REG_ZERO) & (w_rs_hit | w_rt_hit);

endmodule : hazard_stall_ctrl_load_use_detect

// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard controller: load-use stalls (with optional extra memory
// wait cycles), multi-cycle taken-branch squashes and saturating counters.
// Control outputs are decoded combinationally so a stall or flush takes
// effect in the same cycle as the hazard that causes it.
module hazard_stall_ctrl
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int LOAD_EXTRA   = 0,
    parameter int BR_FLUSH_CYC = 1,
    parameter int CNT_W        = 16
) (
    input  logic               clk,
    input  logic               rst,
    hazard_stall_ctrl_if.slave bus
);

    localparam logic [3:0]       LOAD_EXTRA_4 = 4'(LOAD_EXTRA);
    localparam logic [3:0]       BR_REM_4     = 4'(BR_FLUSH_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX      = {CNT_W{1'b1}};

    state_t           r_state;
    state_t           w_state_nxt;
    logic [3:0]       r_rem;
    logic [3:0]       w_rem_nxt;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;
    logic [3:0]       w_ctl;
    logic             w_flush_evt;
    logic             w_lu;

    hazard_stall_ctrl_load_use_detect u_lu (
        .i_id_rs       (bus.id_rs),
        .i_id_rt       (bus.id_rt),
        .i_id_uses_rt  (bus.id_uses_rt),
        .i_ex_mem_read (bus.ex_mem_read),
        .i_ex_rt       (bus.ex_rt),
        .o_lu          (w_lu)
    );

    // Next-state, remaining-cycle and control decode; a taken branch overrides everything.
    always_comb begin
        w_state_nxt = r_state;
        w_rem_nxt   = r_rem;
        w_ctl       = CTL_PASS;
        w_flush_evt = 1'b0;
        if (bus.br_taken) begin
            w_ctl       = CTL_FLUSH;
            w_flush_evt = 1'b1;
            if (BR_FLUSH_CYC > 1) begin
                w_state_nxt = ST_BR_FLUSH;
                w_rem_nxt   = BR_REM_4;
            end else begin
                w_state_nxt = ST_RUN;
                w_rem_nxt   = 4'd0;
            end
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_lu) begin
                        w_ctl = CTL_STALL;
                        if (LOAD_EXTRA > 0) begin
                            w_state_nxt = ST_LU_STALL;
                            w_rem_nxt   = LOAD_EXTRA_4;
                        end else begin
                            w_state_nxt = ST_RUN;
                        end
                    end else begin
                        w_ctl = CTL_PASS;
                    end
                end
                ST_LU_STALL: begin
                    // lu is ignored while the extra memory wait drains
                    w_ctl     = CTL_STALL;
                    w_rem_nxt = r_rem - 4'd1;
                    if (r_rem <= 4'd1) begin
                        w_state_nxt = ST_RUN;
                        w_rem_nxt   = 4'd0;
                    end else begin
                        w_state_nxt = ST_LU_STALL;
                    end
                end
                ST_BR_FLUSH: begin
                    w_ctl     = CTL_FLUSH;
                    w_rem_nxt = r_rem - 4'd1;
                    if (r_rem <= 4'd1) begin
                        w_state_nxt = ST_RUN;
                        w_rem_nxt   = 4'd0;
                    end else begin
                        w_state_nxt = ST_BR_FLUSH;
                    end
                end
                default: begin
                    // unused code 3: pass through and recover to RUN
                    w_ctl       = CTL_PASS;
                    w_state_nxt = ST_RUN;
                    w_rem_nxt   = 4'd0;
                end
            endcase
        end
    end

    // State and remaining-cycle register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_RUN;
            r_rem   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_rem   <= w_rem_nxt;
        end
    end

    // Saturating statistics: stalled cycles (pc_write low) and taken-branch events.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (!w_ctl[3] && (r_stall_cnt != CNT_MAX)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end else begin
                r_stall_cnt <= r_stall_cnt;
            end
            if (w_flush_evt && (r_flush_cnt != CNT_MAX)) begin
                r_flush_cnt <= r_flush_cnt + 1'b1;
            end else begin
                r_flush_cnt <= r_flush_cnt;
            end
        end
    end

    // Reset forces a held, flushed pipeline immediately, independent of the clock.
    assign {bus.pc_write, bus.if_id_write, bus.if_id_flush, bus.id_ex_bubble} =
        rst ? CTL_RESET : w_ctl;
    assign bus.state     = r_state;
    assign bus.stall_cnt = r_stall_cnt;
    assign bus.flush_cnt = r_flush_cnt;

endmodule : hazard_stall_ctrl

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench for hazard_stall_ctrl: three parameterisations share one
// stimulus stream; a reference model counts remaining stall/squash cycles.
module tb_hazard_stall_ctrl;

    typedef struct packed {
        logic [3:0]  ctl;
        logic [1:0]  st;
        logic [15:0] sc;
        logic [15:0] fc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    int le_p[3]  = '{0, 2, 3};
    int br_p[3]  = '{1, 2, 3};
    int max_p[3] = '{65535, 65535, 3};
    int lu_left[3];
    int fl_left[3];
    int scnt[3];
    int fcnt[3];

    always #5 clk = ~clk;

    hazard_stall_ctrl_if #(.CNT_W(16)) i0 ();
    hazard_stall_ctrl_if #(.CNT_W(16)) i1 ();
    hazard_stall_ctrl_if #(.CNT_W(2))  i2 ();

    hazard_stall_ctrl #(.LOAD_EXTRA(0), .BR_FLUSH_CYC(1), .CNT_W(16))
        u0 (.clk(clk), .rst(rst), .bus(i0.slave));
    hazard_stall_ctrl #(.LOAD_EXTRA(2), .BR_FLUSH_CYC(2), .CNT_W(16))
        u1 (.clk(clk), .rst(rst), .bus(i1.slave));
    hazard_stall_ctrl #(.LOAD_EXTRA(3), .BR_FLUSH_CYC(3), .CNT_W(2))
        u2 (.clk(clk), .rst(rst), .bus(i2.slave));

    task automatic chk(input int inst, input exp_t e, input logic [3:0] ctl,
                       input logic [1:0] st, input logic [15:0] sc, input logic [15:0] fc);
        total += 4;
        if (ctl !== e.ctl) begin
            bad++;
            $display("FAIL ctl inst%0d cyc%0d got %b want %b", inst, cyc, ctl, e.ctl);
        end
        if (st !== e.st) begin
            bad++;
            $display("FAIL state inst%0d cyc%0d got %0d want %0d", inst, cyc, st, e.st);
        end
        if (sc !== e.sc) begin
            bad++;
            $display("FAIL stall_cnt inst%0d cyc%0d got %0d want %0d", inst, cyc, sc, e.sc);
        end
        if (fc !== e.fc) begin
            bad++;
            $display("FAIL flush_cnt inst%0d cyc%0d got %0d want %0d", inst, cyc, fc, e.fc);
        end
    endtask

    // Monitor: compare each instance against its oldest expected entry.
    always @(negedge clk) begin
        exp_t e;
        if (q0.size() > 0) begin
            e = q0.pop_front();
            chk(0, e, {i0.pc_write, i0.if_id_write, i0.if_id_flush, i0.id_ex_bubble},
                i0.state, i0.stall_cnt, i0.flush_cnt);
        end
        if (q1.size() > 0) begin
            e = q1.pop_front();
            chk(1, e, {i1.pc_write, i1.if_id_write, i1.if_id_flush, i1.id_ex_bubble},
                i1.state, i1.stall_cnt, i1.flush_cnt);
        end
        if (q2.size() > 0) begin
            e = q2.pop_front();
            chk(2, e, {i2.pc_write, i2.if_id_write, i2.if_id_flush, i2.id_ex_bubble},
                i2.state, 16'(i2.stall_cnt), 16'(i2.flush_cnt));
        end
    end

    // Reference model: outcome of one cycle from remaining stall/squash budgets.
    function automatic exp_t model(input int i, input logic r, input logic lu, input logic bt);
        exp_t e;
        if (r) begin
            e.ctl = 4'b0011; e.st = 2'd0; e.sc = 16'd0; e.fc = 16'd0;
            lu_left[i] = 0; fl_left[i] = 0; scnt[i] = 0; fcnt[i] = 0;
            return e;
        end
        e.st = (fl_left[i] > 0) ? 2'd2 : ((lu_left[i] > 0) ? 2'd1 : 2'd0);
        e.sc = 16'(scnt[i]);
        e.fc = 16'(fcnt[i]);
        if (bt) begin
            e.ctl = 4'b1111;
            if (fcnt[i] < max_p[i]) fcnt[i]++;
            fl_left[i] = br_p[i] - 1;
            lu_left[i] = 0;
        end else if (fl_left[i] > 0) begin
            e.ctl = 4'b1111;
            fl_left[i]--;
        end else if (lu_left[i] > 0) begin
            e.ctl = 4'b0001;
            lu_left[i]--;
        end else if (lu) begin
            e.ctl = 4'b0001;
            lu_left[i] = le_p[i];
        end else begin
            e.ctl = 4'b1100;
        end
        if (e.ctl == 4'b0001 && scnt[i] < max_p[i]) scnt[i]++;
        return e;
    endfunction

    task automatic step(input logic r, input logic [4:0] rs, input logic [4:0] rt,
                        input logic uses, input logic mr, input logic [4:0] exrt,
                        input logic bt);
        logic lu;
        rst = r;
        i0.id_rs = rs; i0.id_rt = rt; i0.id_uses_rt = uses;
        i0.ex_mem_read = mr; i0.ex_rt = exrt; i0.br_taken = bt;
        i1.id_rs = rs; i1.id_rt = rt; i1.id_uses_rt = uses;
        i1.ex_mem_read = mr; i1.ex_rt = exrt; i1.br_taken = bt;
        i2.id_rs = rs; i2.id_rt = rt; i2.id_uses_rt = uses;
        i2.ex_mem_read = mr; i2.ex_rt = exrt; i2.br_taken = bt;
        lu = mr && (exrt != 5'd0) && ((exrt == rs) || (uses && (exrt == rt)));
        q0.push_back(model(0, r, lu, bt));
        q1.push_back(model(1, r, lu, bt));
        q2.push_back(model(2, r, lu, bt));
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 5'd1, 5'd2, 1'b1, 1'b0, 5'd3, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        @(posedge clk);
        #1;
        step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
        step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
        idle(2);
        // single load-use on rs
        step(1'b0, 5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0);
        idle(5);
        // no hazard: ex_rt zero, and rt match without rt use
        step(1'b0, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0);
        step(1'b0, 5'd1, 5'd7, 1'b0, 1'b1, 5'd7, 1'b0);
        // rt match with rt use
        step(1'b0, 5'd1, 5'd7, 1'b1, 1'b1, 5'd7, 1'b0);
        idle(5);
        // branch together with load-use
        step(1'b0, 5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1);
        idle(4);
        // branch during an extended load stall
        step(1'b0, 5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0);
        idle(1);
        step(1'b0, 5'd1, 5'd2, 1'b1, 1'b0, 5'd3, 1'b1);
        idle(4);
        // reset in the middle of a load stall
        step(1'b0, 5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0);
        idle(1);
        step(1'b1, 5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0);
        idle(2);
        // randomized traffic with small register range to provoke hazards
        for (int k = 0; k < 3000; k++) begin
            step(($urandom_range(0, 199) == 0),
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 5'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0));
        end
        repeat (3) @(negedge clk);
        total++;
        if ((q0.size() + q1.size() + q2.size()) != 0) begin
            bad++;
            $display("FAIL drain got %0d pending want 0", q0.size() + q1.size() + q2.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_hazard_stall_ctrl
